wb_region_decoder: RTL and testbench

Parametrised Wishbone (classic, single-outstanding) address decoder and response multiplexer connecting one master (the NeoRV32 external bus) to N memory-mapped slaves. Examples of slaves are the TPM registers, the TPM command buffer, the LiteDRAM data port and the LiteDRAM control port. It replaces ad-hoc per-region hit logic with a table-driven decoder. Over plain decoding, it adds:
- registered single-cycle responses;
- a bus-timeout watchdog;
- configurable unmapped-access handling;
- error capture for firmware diagnostics.

---
 rtl/wb_region_decoder.sv | 221 ++++++++++++++++++++++
 tb/tb_wb_region_decoder.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_region_decoder.sv
// Table-driven Wishbone classic address decoder and response mux for one master and
// N slaves, with registered responses, a bus watchdog and error capture.
module wb_region_decoder #(
    parameter int unsigned               N_SLAVES           = 4,
    parameter int unsigned               DATA_W             = 32,
    parameter logic [32*N_SLAVES-1:0]    SLV_BASE           = {N_SLAVES{32'h0}},
    parameter logic [8*N_SLAVES-1:0]     SLV_AW             = {N_SLAVES{8'd11}},
    parameter int unsigned               TIMEOUT_CYCLES     = 255,
    parameter bit                        UNMAPPED_ERR       = 1'b1,
    parameter logic [DATA_W-1:0]         DEFAULT_READ_VALUE = DATA_W'(32'hBADFABAC)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [31:0]                  m_adr_i,
    input  logic [DATA_W-1:0]            m_dat_i,
    input  logic                         m_we_i,
    input  logic                         m_stb_i,
    input  logic                         m_cyc_i,
    input  logic [DATA_W/8-1:0]          m_sel_i,
    output logic [DATA_W-1:0]            m_dat_o,
    output logic                         m_ack_o,
    output logic                         m_err_o,
    output logic [31:0]                  s_adr_o,
    output logic [DATA_W-1:0]            s_dat_o,
    output logic [DATA_W/8-1:0]          s_sel_o,
    output logic                         s_we_o,
    output logic [N_SLAVES-1:0]          s_cyc_o,
    output logic [N_SLAVES-1:0]          s_stb_o,
    input  logic [N_SLAVES*DATA_W-1:0]   s_dat_i,
    input  logic [N_SLAVES-1:0]          s_ack_i,
    input  logic [N_SLAVES-1:0]          s_err_i,
    output logic                         timeout_o,
    output logic [7:0]                   err_cnt_o,
    output logic [31:0]                  last_err_adr_o
);

    localparam int unsigned SEL_W = DATA_W / 8;
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [N_SLAVES-1:0] r_stb,       w_stb_nxt;
    logic                r_ack,       w_ack_nxt;
    logic                r_err,       w_err_nxt;
    logic                r_timeout,   w_timeout_nxt;
    logic [DATA_W-1:0]   r_m_dat,     w_m_dat_nxt;
    logic [CNT_W-1:0]    r_cnt,       w_cnt_nxt;
    logic [7:0]          r_err_cnt,   w_err_cnt_nxt;
    logic [31:0]         r_last_adr,  w_last_adr_nxt;
    logic [31:0]         r_s_adr;
    logic [DATA_W-1:0]   r_s_dat;
    logic [SEL_W-1:0]    r_s_sel;
    logic                r_s_we;
    logic                w_latch;
    logic                w_found;
    logic [N_SLAVES-1:0] w_hit_oh;
    logic                w_sel_ack;
    logic                w_sel_err;
    logic [DATA_W-1:0]   w_sel_dat;
    logic [31:0]         w_err_adr;

    function automatic logic region_hit(input logic [31:0] adr, input logic [31:0] base,
                                        input logic [7:0] aw);
        logic [32:0] w_low;
        w_low = (33'h1 << aw) - 33'h1;
        return ((adr ^ base) & ~w_low[31:0]) == 32'h0;
    endfunction

    // Region decode, lowest index wins on overlap
    always_comb begin
        w_hit_oh = '0;
        w_found  = 1'b0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (!w_found && region_hit(m_adr_i, SLV_BASE[32*i +: 32], SLV_AW[8*i +: 8])) begin
                w_hit_oh[i] = 1'b1;
                w_found     = 1'b1;
            end
        end
    end

    // Responses are only taken from the slave that owns the current cycle
    always_comb begin
        w_sel_dat = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (r_stb[i]) begin
                w_sel_dat = w_sel_dat | s_dat_i[i*DATA_W +: DATA_W];
            end
        end
        w_sel_ack = |(s_ack_i & r_stb);
        w_sel_err = |(s_err_i & r_stb);
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_stb_nxt      = r_stb;
        w_ack_nxt      = 1'b0;
        w_err_nxt      = 1'b0;
        w_timeout_nxt  = 1'b0;
        w_m_dat_nxt    = r_m_dat;
        w_cnt_nxt      = r_cnt;
        w_err_cnt_nxt  = r_err_cnt;
        w_last_adr_nxt = r_last_adr;
        w_latch        = 1'b0;
        w_err_adr      = r_s_adr;

        case (r_state)
            ST_IDLE: begin
                if (m_cyc_i && m_stb_i) begin
                    w_latch   = 1'b1;
                    w_err_adr = m_adr_i;
                    if (w_found) begin
                        w_stb_nxt   = w_hit_oh;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_BUSY;
                    end else begin
                        w_m_dat_nxt = DEFAULT_READ_VALUE;
                        w_state_nxt = ST_RESP;
                        if (UNMAPPED_ERR) begin
                            w_err_nxt = 1'b1;
                        end else begin
                            w_ack_nxt = 1'b1;
                        end
                    end
                end
            end
            ST_BUSY: begin
                if (!m_cyc_i) begin
                    w_stb_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else if (w_sel_err) begin
                    w_stb_nxt   = '0;
                    w_err_nxt   = 1'b1;
                    w_m_dat_nxt = DEFAULT_READ_VALUE;
                    w_state_nxt = ST_RESP;
                end else if (w_sel_ack) begin
                    w_stb_nxt   = '0;
                    w_ack_nxt   = 1'b1;
                    w_m_dat_nxt = w_sel_dat;
                    w_state_nxt = ST_RESP;
                end else if (TIMEOUT_CYCLES != 0 && r_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
                    w_stb_nxt     = '0;
                    w_err_nxt     = 1'b1;
                    w_timeout_nxt = 1'b1;
                    w_m_dat_nxt   = DEFAULT_READ_VALUE;
                    w_state_nxt   = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_stb_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Error bookkeeping lands in the same cycle the error response is shown
        if (w_err_nxt) begin
            w_last_adr_nxt = w_err_adr;
            if (r_err_cnt != 8'hFF) begin
                w_err_cnt_nxt = r_err_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_stb      <= '0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_timeout  <= 1'b0;
            r_m_dat    <= '0;
            r_cnt      <= '0;
            r_err_cnt  <= '0;
            r_last_adr <= '0;
            r_s_adr    <= '0;
            r_s_dat    <= '0;
            r_s_sel    <= '0;
            r_s_we     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_stb      <= w_stb_nxt;
            r_ack      <= w_ack_nxt;
            r_err      <= w_err_nxt;
            r_timeout  <= w_timeout_nxt;
            r_m_dat    <= w_m_dat_nxt;
            r_cnt      <= w_cnt_nxt;
            r_err_cnt  <= w_err_cnt_nxt;
            r_last_adr <= w_last_adr_nxt;
            if (w_latch) begin
                r_s_adr <= m_adr_i;
                r_s_dat <= m_dat_i;
                r_s_sel <= m_sel_i;
                r_s_we  <= m_we_i;
            end
        end
    end

    assign m_dat_o        = r_m_dat;
    assign m_ack_o        = r_ack;
    assign m_err_o        = r_err;
    assign s_adr_o        = r_s_adr;
    assign s_dat_o        = r_s_dat;
    assign s_sel_o        = r_s_sel;
    assign s_we_o         = r_s_we;
    assign s_cyc_o        = r_stb;
    assign s_stb_o        = r_stb;
    assign timeout_o      = r_timeout;
    assign err_cnt_o      = r_err_cnt;
    assign last_err_adr_o = r_last_adr;

endmodule

// File: tb/tb_wb_region_decoder.sv
// Directed bench for wb_region_decoder: a vector table of single transfers plus
// hand sequences for abort, reset-in-busy, back-to-back writes and counter saturation.
module tb_wb_region_decoder;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam logic [32*N-1:0] BASE  = {32'hF8000000, 32'h80000000, 32'hF0000800, 32'hF0000000};
    localparam logic [8*N-1:0]  AW    = {8'd14, 8'd27, 8'd11, 8'd11};
    localparam logic [32*N-1:0] BASE2 = {32'hF8000000, 32'h80000000, 32'hF0000000, 32'hF0000000};
    localparam logic [8*N-1:0]  AW2   = {8'd14, 8'd27, 8'd16, 8'd11};
    localparam logic [31:0] DEF = 32'hBADFABAC;
    localparam logic [1:0] M_ACK = 2'd0, M_ERR = 2'd1, M_BOTH = 2'd2, M_NONE = 2'd3;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wdat;
        int          tgt;
        logic [1:0]  mode;
        logic [31:0] rdat;
        logic [3:0]  exp_stb;
        logic        exp_ack;
        logic        exp_err;
        logic [31:0] exp_dat;
        int          exp_lat;
        int          exp_stb_cyc;
        int          exp_to;
    } vec_t;

    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    // main DUT: unmapped -> err, watchdog 8
    logic [31:0]     m_adr_i, m_dat_i, m_dat_o, s_adr_o, s_dat_o, last_err_adr_o;
    logic            m_we_i, m_stb_i, m_cyc_i, m_ack_o, m_err_o, s_we_o, timeout_o;
    logic [3:0]      m_sel_i, s_sel_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i;
    logic [N*DW-1:0] s_dat_i;
    logic [7:0]      err_cnt_o;

    // second DUT: unmapped -> ack, watchdog off, overlapping map
    logic [31:0]     m2_adr_i, m2_dat_i, m2_dat_o, s2_adr_o, s2_dat_o, last2_err_adr_o;
    logic            m2_we_i, m2_stb_i, m2_cyc_i, m2_ack_o, m2_err_o, s2_we_o, timeout2_o;
    logic [3:0]      m2_sel_i, s2_sel_o, s2_cyc_o, s2_stb_o, s2_ack_i, s2_err_i;
    logic [N*DW-1:0] s2_dat_i;
    logic [7:0]      err2_cnt_o;

    int          slv_tgt;
    logic [1:0]  slv_mode;
    logic [31:0] slv_rdat;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          mdl_cnt = 0;
    logic [31:0] mdl_last = 32'h0;

    wb_region_decoder #(
        .N_SLAVES(N), .DATA_W(DW), .SLV_BASE(BASE), .SLV_AW(AW),
        .TIMEOUT_CYCLES(8), .UNMAPPED_ERR(1'b1), .DEFAULT_READ_VALUE(DEF)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_we_i(m_we_i), .m_stb_i(m_stb_i),
        .m_cyc_i(m_cyc_i), .m_sel_i(m_sel_i), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
        .m_err_o(m_err_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .timeout_o(timeout_o),
        .err_cnt_o(err_cnt_o), .last_err_adr_o(last_err_adr_o)
    );

    wb_region_decoder #(
        .N_SLAVES(N), .DATA_W(DW), .SLV_BASE(BASE2), .SLV_AW(AW2),
        .TIMEOUT_CYCLES(0), .UNMAPPED_ERR(1'b0), .DEFAULT_READ_VALUE(DEF)
    ) dut2 (
        .clk_i(clk), .rst_i(rst_i),
        .m_adr_i(m2_adr_i), .m_dat_i(m2_dat_i), .m_we_i(m2_we_i), .m_stb_i(m2_stb_i),
        .m_cyc_i(m2_cyc_i), .m_sel_i(m2_sel_i), .m_dat_o(m2_dat_o), .m_ack_o(m2_ack_o),
        .m_err_o(m2_err_o), .s_adr_o(s2_adr_o), .s_dat_o(s2_dat_o), .s_sel_o(s2_sel_o),
        .s_we_o(s2_we_o), .s_cyc_o(s2_cyc_o), .s_stb_o(s2_stb_o), .s_dat_i(s2_dat_i),
        .s_ack_i(s2_ack_i), .s_err_i(s2_err_i), .timeout_o(timeout2_o),
        .err_cnt_o(err2_cnt_o), .last_err_adr_o(last2_err_adr_o)
    );

    // Target slave answers combinationally to its strobe; all others shout ack+err constantly
    always_comb begin
        s_ack_i = '0;
        s_err_i = '0;
        s_dat_i = '0;
        for (int i = 0; i < N; i++) begin
            if (i == slv_tgt) begin
                s_ack_i[i] = s_stb_o[i] & (slv_mode == M_ACK || slv_mode == M_BOTH);
                s_err_i[i] = s_stb_o[i] & (slv_mode == M_ERR || slv_mode == M_BOTH);
                s_dat_i[i*DW +: DW] = slv_rdat;
            end else begin
                s_ack_i[i] = 1'b1;
                s_err_i[i] = 1'b1;
                s_dat_i[i*DW +: DW] = 32'h0BAD0000 | 32'(i);
            end
        end
    end

    assign s2_ack_i = s2_stb_o;
    assign s2_err_i = '0;
    assign s2_dat_i = {32'hD0000003, 32'hD0000002, 32'hD0000001, 32'hD0000000};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkv(logic [31:0] adr, logic we, logic [3:0] sel, logic [31:0] wdat,
                                 int tgt, logic [1:0] mode, logic [31:0] rdat, logic [3:0] estb,
                                 logic eack, logic eerr, logic [31:0] edat, int elat, int escyc,
                                 int eto);
        vec_t v;
        v.adr = adr; v.we = we; v.sel = sel; v.wdat = wdat; v.tgt = tgt; v.mode = mode;
        v.rdat = rdat; v.exp_stb = estb; v.exp_ack = eack; v.exp_err = eerr; v.exp_dat = edat;
        v.exp_lat = elat; v.exp_stb_cyc = escyc; v.exp_to = eto;
        return v;
    endfunction

    task automatic model_err(input logic [31:0] adr);
        mdl_cnt  = (mdl_cnt == 255) ? 255 : mdl_cnt + 1;
        mdl_last = adr;
    endtask

    task automatic run_xfer(input vec_t v, input string nm);
        int lat, stb_cyc, to_cnt;
        logic [3:0] stb_or;
        m_adr_i = v.adr; m_we_i = v.we; m_sel_i = v.sel; m_dat_i = v.wdat;
        m_cyc_i = 1'b1; m_stb_i = 1'b1;
        slv_tgt = v.tgt; slv_mode = v.mode; slv_rdat = v.rdat;
        lat = 0; stb_cyc = 0; to_cnt = 0; stb_or = '0;
        do begin
            tick();
            lat++;
            if (s_stb_o != 4'b0) stb_cyc++;
            stb_or = stb_or | s_stb_o;
            if (timeout_o) to_cnt++;
        end while (!(m_ack_o || m_err_o) && lat < 40);
        if (v.exp_err) model_err(v.adr);
        chk({nm, " ack"}, 32'(m_ack_o), 32'(v.exp_ack));
        chk({nm, " err"}, 32'(m_err_o), 32'(v.exp_err));
        chk({nm, " dat"}, m_dat_o, v.exp_dat);
        chk({nm, " latency"}, 32'(lat), 32'(v.exp_lat));
        chk({nm, " stb bits"}, 32'(stb_or), 32'(v.exp_stb));
        chk({nm, " stb cycles"}, 32'(stb_cyc), 32'(v.exp_stb_cyc));
        chk({nm, " timeout pulses"}, 32'(to_cnt), 32'(v.exp_to));
        chk({nm, " stb at resp"}, 32'(s_stb_o), 32'h0);
        chk({nm, " err_cnt"}, 32'(err_cnt_o), 32'(mdl_cnt));
        chk({nm, " last_err_adr"}, last_err_adr_o, mdl_last);
        chk({nm, " s_adr"}, s_adr_o, v.adr);
        chk({nm, " s_we"}, 32'(s_we_o), 32'(v.we));
        chk({nm, " s_sel"}, 32'(s_sel_o), 32'(v.sel));
        chk({nm, " s_dat"}, s_dat_o, v.wdat);
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        tick();
        chk({nm, " single-cycle resp"}, 32'(m_ack_o | m_err_o), 32'h0);
    endtask

    task automatic xfer2(input logic [31:0] adr, input logic we, input logic [3:0] exp_stb,
                         input logic [31:0] exp_dat, input int exp_lat, input string nm);
        int lat;
        logic [3:0] stb_or;
        m2_adr_i = adr; m2_we_i = we; m2_cyc_i = 1'b1; m2_stb_i = 1'b1;
        lat = 0; stb_or = '0;
        do begin
            tick();
            lat++;
            stb_or = stb_or | s2_stb_o;
        end while (!(m2_ack_o || m2_err_o) && lat < 40);
        chk({nm, " ack"}, 32'(m2_ack_o), 32'h1);
        chk({nm, " err"}, 32'(m2_err_o), 32'h0);
        chk({nm, " dat"}, m2_dat_o, exp_dat);
        chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, " stb bits"}, 32'(stb_or), 32'(exp_stb));
        chk({nm, " err_cnt"}, 32'(err2_cnt_o), 32'h0);
        m2_cyc_i = 1'b0; m2_stb_i = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global time limit reached");
        $fatal(1, "bench time limit");
    end

    initial begin
        vec_t vecs[12];
        int   resp, acks, errs, overlap, sel_bad, lost, w;
        logic [3:0] stb_or;
        logic [31:0] adr;

        vecs[0]  = mkv(32'hF0000804, 1'b0, 4'hF, 32'h0, 1, M_ACK, 32'h12345678, 4'b0010, 1'b1, 1'b0, 32'h12345678, 2, 1, 0);
        vecs[1]  = mkv(32'hF8000004, 1'b0, 4'hF, 32'h0, 3, M_ACK, 32'hCAFEF00D, 4'b1000, 1'b1, 1'b0, 32'hCAFEF00D, 2, 1, 0);
        vecs[2]  = mkv(32'hF0000000, 1'b0, 4'hF, 32'h0, 0, M_ACK, 32'h00000001, 4'b0001, 1'b1, 1'b0, 32'h00000001, 2, 1, 0);
        vecs[3]  = mkv(32'h87FFFFFC, 1'b0, 4'hF, 32'h0, 2, M_ACK, 32'hA5A5A5A5, 4'b0100, 1'b1, 1'b0, 32'hA5A5A5A5, 2, 1, 0);
        vecs[4]  = mkv(32'h88000000, 1'b0, 4'hF, 32'h0, 2, M_ACK, 32'h0,        4'b0000, 1'b0, 1'b1, DEF,          1, 0, 0);
        vecs[5]  = mkv(32'h40000000, 1'b0, 4'hF, 32'h0, 0, M_ACK, 32'h0,        4'b0000, 1'b0, 1'b1, DEF,          1, 0, 0);
        vecs[6]  = mkv(32'hF8003FFC, 1'b0, 4'hF, 32'h0, 3, M_ERR, 32'h11111111, 4'b1000, 1'b0, 1'b1, DEF,          2, 1, 0);
        vecs[7]  = mkv(32'hF8004000, 1'b0, 4'hF, 32'h0, 3, M_ACK, 32'h0,        4'b0000, 1'b0, 1'b1, DEF,          1, 0, 0);
        vecs[8]  = mkv(32'hF0000FFC, 1'b0, 4'hF, 32'h0, 1, M_BOTH, 32'h22222222, 4'b0010, 1'b0, 1'b1, DEF,         2, 1, 0);
        vecs[9]  = mkv(32'hF0000400, 1'b0, 4'hF, 32'h0, 0, M_NONE, 32'h0,       4'b0001, 1'b0, 1'b1, DEF,          10, 9, 1);
        vecs[10] = mkv(32'hF0000020, 1'b1, 4'h3, 32'h11223344, 0, M_ACK, 32'h55AA55AA, 4'b0001, 1'b1, 1'b0, 32'h55AA55AA, 2, 1, 0);
        vecs[11] = mkv(32'hF00007FC, 1'b0, 4'hF, 32'h0, 0, M_ACK, 32'h0F0F0F0F, 4'b0001, 1'b1, 1'b0, 32'h0F0F0F0F, 2, 1, 0);

        m_adr_i = '0; m_dat_i = '0; m_we_i = 1'b0; m_stb_i = 1'b0; m_cyc_i = 1'b0; m_sel_i = '0;
        m2_adr_i = '0; m2_dat_i = '0; m2_we_i = 1'b0; m2_stb_i = 1'b0; m2_cyc_i = 1'b0; m2_sel_i = 4'hF;
        slv_tgt = 0; slv_mode = M_NONE; slv_rdat = '0;
        rst_i = 1'b1;
        repeat (3) tick();
        rst_i = 1'b0;
        tick();

        chk("reset stb", 32'(s_stb_o), 32'h0);
        chk("reset cyc", 32'(s_cyc_o), 32'h0);
        chk("reset ack/err/timeout", 32'({m_ack_o, m_err_o, timeout_o}), 32'h0);
        chk("reset m_dat", m_dat_o, 32'h0);
        chk("reset err_cnt", 32'(err_cnt_o), 32'h0);
        chk("reset last_err_adr", last_err_adr_o, 32'h0);
        chk("reset s_adr", s_adr_o, 32'h0);
        chk("reset s_dat", s_dat_o, 32'h0);
        chk("reset s_sel/s_we", 32'({s_sel_o, s_we_o}), 32'h0);

        for (int i = 0; i < 12; i++) begin
            run_xfer(vecs[i], $sformatf("vec%0d", i));
        end

        // master abort while busy
        slv_tgt = 2; slv_mode = M_NONE;
        m_adr_i = 32'h80000010; m_we_i = 1'b0; m_sel_i = 4'hF; m_cyc_i = 1'b1; m_stb_i = 1'b1;
        tick();
        chk("abort stb busy", 32'(s_stb_o), 32'h4);
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        tick();
        chk("abort stb dropped", 32'(s_stb_o), 32'h0);
        resp = (m_ack_o || m_err_o) ? 1 : 0;
        repeat (4) begin
            tick();
            if (m_ack_o || m_err_o) resp++;
        end
        chk("abort no response", 32'(resp), 32'h0);
        run_xfer(vecs[2], "after abort");

        // reset while busy
        slv_tgt = 0; slv_mode = M_NONE;
        m_adr_i = 32'hF0000100; m_cyc_i = 1'b1; m_stb_i = 1'b1;
        tick();
        chk("rst-busy stb", 32'(s_stb_o), 32'h1);
        rst_i = 1'b1;
        tick();
        mdl_cnt = 0; mdl_last = 32'h0;
        chk("rst-busy stb dropped", 32'(s_stb_o), 32'h0);
        chk("rst-busy err_cnt", 32'(err_cnt_o), 32'h0);
        rst_i = 1'b0; m_cyc_i = 1'b0; m_stb_i = 1'b0;
        resp = (m_ack_o || m_err_o) ? 1 : 0;
        repeat (4) begin
            tick();
            if (m_ack_o || m_err_o) resp++;
        end
        chk("rst-busy no response", 32'(resp), 32'h0);
        run_xfer(vecs[0], "after reset");

        // back-to-back writes, master renews the request right after each ack
        m_we_i = 1'b1; m_sel_i = 4'b0011; m_adr_i = 32'hF0000040; m_dat_i = 32'hAAAA0001;
        slv_tgt = 0; slv_mode = M_ACK; slv_rdat = 32'h0;
        m_cyc_i = 1'b1; m_stb_i = 1'b1;
        acks = 0; errs = 0; overlap = 0; sel_bad = 0; stb_or = '0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if ($countones(s_stb_o) > 1) overlap++;
            stb_or = stb_or | s_stb_o;
            if (s_stb_o != 4'b0 && (s_sel_o != 4'b0011 || !s_we_o)) sel_bad++;
            if (m_err_o) errs++;
            if (m_ack_o) begin
                acks++;
                if (acks == 1) begin
                    m_adr_i = 32'hF0000840; m_dat_i = 32'hAAAA0002; slv_tgt = 1;
                end else begin
                    m_cyc_i = 1'b0; m_stb_i = 1'b0;
                end
            end
        end
        chk("b2b acks", 32'(acks), 32'h2);
        chk("b2b errs", 32'(errs), 32'h0);
        chk("b2b stb overlap", 32'(overlap), 32'h0);
        chk("b2b sel/we during stb", 32'(sel_bad), 32'h0);
        chk("b2b stb bits", 32'(stb_or), 32'h3);
        chk("b2b s_sel", 32'(s_sel_o), 32'h3);
        chk("b2b s_we", 32'(s_we_o), 32'h1);
        chk("b2b s_dat", s_dat_o, 32'hAAAA0002);

        // error counter saturation
        m_we_i = 1'b0; m_sel_i = 4'hF; slv_tgt = 1; slv_mode = M_BOTH;
        lost = 0;
        for (int k = 0; k < 300; k++) begin
            adr = k[0] ? (32'h40000000 | (32'(k) << 2)) : 32'hF0000C00;
            m_adr_i = adr; m_cyc_i = 1'b1; m_stb_i = 1'b1;
            w = 0;
            do begin
                tick();
                w++;
            end while (!m_err_o && w < 20);
            if (!m_err_o) lost++;
            model_err(adr);
            m_cyc_i = 1'b0; m_stb_i = 1'b0;
            tick();
        end
        chk("sat all errored", 32'(lost), 32'h0);
        chk("sat err_cnt", 32'(err_cnt_o), 32'(mdl_cnt));
        chk("sat err_cnt is 255", 32'(err_cnt_o), 32'd255);
        chk("sat last_err_adr", last_err_adr_o, mdl_last);

        // unmapped-ack flavour and overlapping regions
        xfer2(32'h40000000, 1'b0, 4'b0000, DEF, 1, "d2 unmapped read");
        xfer2(32'h40000004, 1'b1, 4'b0000, DEF, 1, "d2 unmapped write");
        xfer2(32'hF0000010, 1'b0, 4'b0001, 32'hD0000000, 2, "d2 overlap low wins");
        xfer2(32'hF0001000, 1'b0, 4'b0010, 32'hD0000001, 2, "d2 wide region");
        xfer2(32'hF000FFFC, 1'b0, 4'b0010, 32'hD0000001, 2, "d2 wide top");
        xfer2(32'hF0010000, 1'b0, 4'b0000, DEF, 1, "d2 above wide");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
